// File: rtl/motor_step_controller.sv
// Four-coil stepper sequencer: full-step phase walk toward a commanded target, settle, then done.
// Optional MOTOR_COIL_RELEASE_EN de-energises the coils after a long idle stretch.
module motor_step_controller #(
    parameter int POS_W          = 12,
    parameter int DIV_W          = 16,
    parameter int STEP_DIV       = 50000,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int RELEASE_CYCLES = 100000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [POS_W-1:0] cmd_target_i,
    input  logic             pos_load_i,
    input  logic [POS_W-1:0] pos_load_val_i,
    input  logic             estop_i,
    output logic [3:0]       motor_signals_o,
    output logic [POS_W-1:0] position_o,
    output logic             moving_o,
    output logic             dir_up_o,
    output logic             done_o,
    output logic             aborted_o
);

    localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] tgt_q, tgt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SET_W-1:0] set_q, set_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic [3:0]       coil_q, coil_d;
    logic             handshake;
    logic [POS_W-1:0] pos_step;

    function automatic logic [3:0] phase_pat(input logic [1:0] i);
        case (i)
            2'd0:    phase_pat = 4'b1001;
            2'd1:    phase_pat = 4'b1100;
            2'd2:    phase_pat = 4'b0110;
            default: phase_pat = 4'b0011;
        endcase
    endfunction

    assign cmd_ready_o = (state_q == IDLE) && !estop_i;
    assign handshake   = cmd_valid_i && cmd_ready_o;
    assign pos_step    = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        div_d   = div_q;
        set_d   = set_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (cmd_target_i == pos_q) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d   = cmd_target_i > pos_q;
                        tgt_d   = cmd_target_i;
                        div_d   = '0;
                        state_d = RUN;
                    end
                end else if (pos_load_i) begin
                    pos_d = pos_load_val_i;
                end
            end
            RUN: begin
                if (estop_i) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    idx_d = dir_q ? idx_q + 2'd1 : idx_q - 2'd1;
                    pos_d = pos_step;
                    if (pos_step == tgt_q) begin
                        set_d   = '0;
                        state_d = SETTLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SETTLE: begin
                if (estop_i) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (set_q == SET_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MOTOR_COIL_RELEASE_EN
    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_CYCLES);

    logic [REL_W-1:0] idle_q, idle_d;

    // Any handshake (including a zero-length one) restarts the count and re-energises at once.
    always_comb begin
        idle_d = '0;
        if (state_q == IDLE && !handshake)
            idle_d = (idle_q == REL_MAX) ? idle_q : idle_q + 1'b1;
        coil_d = (idle_d == REL_MAX) ? 4'b0000 : phase_pat(idx_d);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`else
    assign coil_d = phase_pat(idx_d);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            pos_q   <= '0;
            tgt_q   <= '0;
            div_q   <= '0;
            set_q   <= '0;
            dir_q   <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            coil_q  <= 4'b1001;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            div_q   <= div_d;
            set_q   <= set_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            coil_q  <= coil_d;
        end
    end

    assign motor_signals_o = coil_q;
    assign position_o      = pos_q;
    assign moving_o        = (state_q == RUN) || (state_q == SETTLE);
    assign dir_up_o        = dir_q;
    assign done_o          = done_q;
    assign aborted_o       = abort_q;

endmodule
